// File: rtl/vga_scan_driver.sv
// vga_scan_driver: 640x480@60 VGA timing, pixel coordinates, per-frame audio latch and registered DAC outputs
module vga_scan_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 10,
    parameter int AW       = 16
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [CW-1:0] iR,
    input  logic [CW-1:0] iG,
    input  logic [CW-1:0] iB,
    input  logic [AW-1:0] iAudL,
    input  logic [AW-1:0] iAudR,
    output logic [9:0]    oX,
    output logic [9:0]    oY,
    output logic [AW-1:0] oAudL,
    output logic [AW-1:0] oAudR,
    output logic [CW-1:0] oVGA_R,
    output logic [CW-1:0] oVGA_G,
    output logic [CW-1:0] oVGA_B,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oVGA_BLANK,
    output logic          oFrameStart
);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HT  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VT  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CW-1:0] r_q, g_q, b_q;
    logic [AW-1:0] aud_l_q, aud_r_q;
    logic          hs_q, vs_q, blank_q, fs_q;
    logic          h_wrap, active, hs_d, vs_d, aud_cap;

    // Next counter position, and visibility/sync decode of the current pixel
    always_comb begin
        h_wrap  = hcnt_q == HT - 10'd1;
        hcnt_d  = h_wrap ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d  = h_wrap ? ((vcnt_q == VT - 10'd1) ? 10'd0 : vcnt_q + 10'd1) : vcnt_q;
        active  = hcnt_q < HA && vcnt_q < VA;
        hs_d    = !(hcnt_q >= HS0 && hcnt_q < HS1);
        vs_d    = !(vcnt_q >= VS0 && vcnt_q < VS1);
        aud_cap = h_wrap && vcnt_q == VA - 10'd1;
    end

    // Counters plus one output stage so sync, blank and colour leave on the same edge
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            aud_l_q <= '0;
            aud_r_q <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            r_q     <= active ? iR : '0;
            g_q     <= active ? iG : '0;
            b_q     <= active ? iB : '0;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= active;
            fs_q    <= hcnt_q == 10'd0 && vcnt_q == 10'd0;
            if (aud_cap) begin
                aud_l_q <= iAudL;
                aud_r_q <= iAudR;
            end
        end
    end

    assign oX          = hcnt_q;
    assign oY          = vcnt_q;
    assign oAudL       = aud_l_q;
    assign oAudR       = aud_r_q;
    assign oVGA_R      = r_q;
    assign oVGA_G      = g_q;
    assign oVGA_B      = b_q;
    assign oVGA_HS     = hs_q;
    assign oVGA_VS     = vs_q;
    assign oVGA_BLANK  = blank_q;
    assign oFrameStart = fs_q;
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: scoreboard bench for vga_scan_driver on a shrunken screen geometry
module tb_vga_scan_driver;
    // Small geometry so several whole frames fit in a short run; same structure as 640x480
    localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [9:0]  x, y;
        logic [9:0]  r, g, b;
        logic        hs, vs, bl, fs;
        logic [15:0] al, ar;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [9:0]  ir, ig, ib, ox, oy, vr, vg, vb;
    logic [15:0] aud_l = '0, aud_r = '0, oal, oar;
    logic        hs_o, vs_o, bl_o, fs_o;

    exp_t sb[$];
    exp_t m;
    int   n_cmp = 0, n_bad = 0;
    int   c = 0, f = 0;
    logic [15:0] al_m = '0, ar_m = '0;

    always #5 clk = ~clk;

    assign ir = ox;
    assign ig = oy;
    assign ib = 10'h3FF;

    vga_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CW(10), .AW(16)
    ) dut (
        .iCLK(clk), .iRST(rst), .iR(ir), .iG(ig), .iB(ib),
        .iAudL(aud_l), .iAudR(aud_r), .oX(ox), .oY(oy),
        .oAudL(oal), .oAudR(oar), .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb),
        .oVGA_HS(hs_o), .oVGA_VS(vs_o), .oVGA_BLANK(bl_o), .oFrameStart(fs_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; the expected post-edge state comes from the pixel index c
    task automatic step(input logic r);
        exp_t e;
        int h, v;
        logic act;
        @(negedge clk);
        rst = r;
        h = c % HT;
        v = c / HT;
        aud_l = (((v % 2) ^ (f % 2)) != 0) ? 16'hABCD : 16'h1234;
        aud_r = ~aud_l;
        e = '0;
        if (r) begin
            c = 0; f = 0; al_m = '0; ar_m = '0;
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            act  = h < HA && v < VA;
            e.r  = act ? 10'(h) : 10'd0;
            e.g  = act ? 10'(v) : 10'd0;
            e.b  = act ? 10'h3FF : 10'd0;
            e.bl = act;
            e.hs = !(h >= HA + HF && h < HA + HF + HS);
            e.vs = !(v >= VA + VF && v < VA + VF + VS);
            e.fs = c == 0;
            if (h == HT - 1 && v == VA - 1) begin
                al_m = aud_l;
                ar_m = aud_r;
            end
            c++;
            if (c == HT * VT) begin
                c = 0;
                f++;
            end
            e.x = 10'(c % HT);
            e.y = 10'(c / HT);
        end
        e.al = al_m;
        e.ar = ar_m;
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents a new pixel every edge, so pop one expectation per edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            chk("timing", 64'({ox, oy, hs_o, vs_o, bl_o, fs_o}), 64'({m.x, m.y, m.hs, m.vs, m.bl, m.fs}));
            chk("colour", 64'({vr, vg, vb}), 64'({m.r, m.g, m.b}));
            chk("audio", 64'({oal, oar}), 64'({m.al, m.ar}));
        end
    end

    initial begin
        repeat (5) step(1'b1);
        repeat (3 * HT * VT + 3 * HT + 10) step(1'b0);
        repeat (5) step(1'b1);
        repeat (2 * HT * VT + 40) step(1'b0);
        repeat (4) @(posedge clk);
        #2;
        chk("drain", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
